// File: rtl/rom_boot_loader_pkg.sv
// Shared types and constants for the Hack boot loader: FSM state encoding,
// default frame start marker and a state-class helper.
package rom_boot_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      CSUM_HI,
      CSUM_LO,
      RUN,
      ERROR
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

   // States in which the loader is willing to take a byte from the host link.
   function automatic logic is_receiving(state_t s);
      return s inside {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO};
   endfunction

endpackage : rom_boot_loader_pkg

// File: rtl/rom_boot_loader_checksum16.sv
// 16-bit modular sum of the image words; only built when
// ROM_BOOT_LOADER_CHECKSUM_EN is defined, since only then is it instantiated.
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
module checksum16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        add_en,
   input  logic [15:0] word,
   output logic [15:0] sum
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sum + word;
      end
   end

endmodule : checksum16
`endif

// File: rtl/rom_boot_loader.sv
// Boot loader: receives a framed program image byte-wise, writes it to ROM from
// address 0 and then releases the CPU. Optional checksum: ROM_BOOT_LOADER_CHECKSUM_EN.
module rom_boot_loader
   import rom_boot_loader_pkg::*;
#(
   parameter int         ADDR_W    = 15,
   parameter int         MAX_WORDS = 32768,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       rom_wdata,
   output logic              cpu_reset,
   output logic              loaded,
   output logic              error
);

`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
   localparam state_t DONE_STATE = CSUM_HI;
`else
   localparam state_t DONE_STATE = RUN;
`endif

   state_t            state_q, state_d;
   logic [7:0]        byte_hi_q, byte_hi_d;
   logic [15:0]       word_count_q, word_count_d;
   logic [15:0]       index_q, index_d;
   logic [15:0]       rx_word;
   logic              accept;

   logic              rx_ready_d, rom_we_d, cpu_reset_d, loaded_d, error_d;
   logic [ADDR_W-1:0] rom_addr_d;
   logic [15:0]       rom_wdata_d;

   assign accept  = rx_valid && rx_ready;
   // The high byte of every two-byte field shares one holding register.
   assign rx_word = {byte_hi_q, rx_data};

`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
   logic [15:0] sum;
   logic        sum_clear;
   logic        sum_add;

   assign sum_clear = !load_req && (state_q == IDLE) && accept && (rx_data == SYNC_BYTE);
   assign sum_add   = !load_req && (state_q == WRITE);

   checksum16 u_checksum (
      .clk    (clk),
      .reset  (reset),
      .clear  (sum_clear),
      .add_en (sum_add),
      .word   (rom_wdata),
      .sum    (sum)
   );
`endif

   // NOTE: every variable written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      byte_hi_d    = byte_hi_q;
      word_count_d = word_count_q;
      index_d      = index_q;
      rom_addr_d   = rom_addr;
      rom_wdata_d  = rom_wdata;

      if (load_req) begin
         state_d = IDLE;
         index_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && (rx_data == SYNC_BYTE)) state_d = CNT_HI;
            end
            CNT_HI: begin
               if (accept) begin
                  byte_hi_d = rx_data;
                  state_d   = CNT_LO;
               end
            end
            CNT_LO: begin
               if (accept) begin
                  word_count_d = rx_word;
                  index_d      = '0;
                  if (rx_word == 16'd0) begin
                     state_d = DONE_STATE;
                  end else if ({16'd0, rx_word} > 32'(MAX_WORDS)) begin
                     state_d = ERROR;
                  end else begin
                     state_d = DATA_HI;
                  end
               end
            end
            DATA_HI: begin
               if (accept) begin
                  byte_hi_d = rx_data;
                  state_d   = DATA_LO;
               end
            end
            DATA_LO: begin
               if (accept) begin
                  rom_wdata_d = rx_word;
                  rom_addr_d  = index_q[ADDR_W-1:0];
                  state_d     = WRITE;
               end
            end
            WRITE: begin
               index_d = index_q + 16'd1;
               if (index_q == word_count_q - 16'd1) begin
                  state_d = DONE_STATE;
               end else begin
                  state_d = DATA_HI;
               end
            end
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
            CSUM_HI: begin
               if (accept) begin
                  byte_hi_d = rx_data;
                  state_d   = CSUM_LO;
               end
            end
            CSUM_LO: begin
               if (accept) state_d = (rx_word == sum) ? RUN : ERROR;
            end
`endif
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
         endcase
      end

      // Outputs are a decode of the next state so that they register in step with it.
      rx_ready_d  = is_receiving(state_d);
      rom_we_d    = (state_d == WRITE);
      cpu_reset_d = (state_d != RUN);
      loaded_d    = (state_d == RUN);
      error_d     = (state_d == ERROR);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_hi_q    <= '0;
         word_count_q <= '0;
         index_q      <= '0;
         rx_ready     <= 1'b1;
         rom_we       <= 1'b0;
         rom_addr     <= '0;
         rom_wdata    <= '0;
         cpu_reset    <= 1'b1;
         loaded       <= 1'b0;
         error        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_hi_q    <= byte_hi_d;
         word_count_q <= word_count_d;
         index_q      <= index_d;
         rx_ready     <= rx_ready_d;
         rom_we       <= rom_we_d;
         rom_addr     <= rom_addr_d;
         rom_wdata    <= rom_wdata_d;
         cpu_reset    <= cpu_reset_d;
         loaded       <= loaded_d;
         error        <= error_d;
      end
   end

endmodule : rom_boot_loader

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: a per-cycle vector table for the main
// frames plus byte-stream sequences with gaps and checksum frames.
module tb_rom_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        load_req;
   logic        rom_we;
   logic [14:0] rom_addr;
   logic [15:0] rom_wdata;
   logic        cpu_reset;
   logic        loaded;
   logic        error;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic        rdy;
      logic        we;
      logic [14:0] addr;
      logic [15:0] wd;
      logic        cr;
      logic        ld;
      logic        er;
   } out_t;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       lreq;
      out_t       exp;
   } vec_t;

   vec_t        vecs[$];
   logic [14:0] wr_addr[$];
   logic [15:0] wr_data[$];

   always #5 clk = ~clk;

   rom_boot_loader dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .load_req  (load_req),
      .rom_we    (rom_we),
      .rom_addr  (rom_addr),
      .rom_wdata (rom_wdata),
      .cpu_reset (cpu_reset),
      .loaded    (loaded),
      .error     (error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic out_t cur_out();
      out_t o;
      o = {rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, loaded, error};
      return o;
   endfunction

   task automatic v(input logic [7:0] data, input logic valid, input logic lreq,
                    input logic rdy, input logic we, input logic [14:0] addr,
                    input logic [15:0] wd, input logic cr, input logic ld, input logic er);
      vec_t t;
      t.data  = data;
      t.valid = valid;
      t.lreq  = lreq;
      t.exp   = {rdy, we, addr, wd, cr, ld, er};
      vecs.push_back(t);
   endtask

   task automatic pulse_load();
      @(negedge clk);
      load_req = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic record_write();
      if (rom_we) begin
         wr_addr.push_back(rom_addr);
         wr_data.push_back(rom_wdata);
      end
   endtask

   // Streams bytes with rx_valid high on roughly duty% of cycles, logging writes.
   task automatic send_frame(input logic [7:0] bytes[$], input int duty);
      int   idx = 0;
      int   cyc = 0;
      logic acc;
      wr_addr.delete();
      wr_data.delete();
      while (idx < bytes.size() && cyc < 2000) begin
         @(negedge clk);
         rx_valid = ($urandom_range(0, 99) < duty);
         rx_data  = bytes[idx];
         acc      = rx_valid && rx_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         record_write();
         cyc++;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         record_write();
      end
      check("frame_bytes_accepted", idx, bytes.size());
   endtask

   initial begin
      logic [7:0] frame[$];
      logic [14:0] exp_addr[4];
      logic [15:0] exp_data[4];

      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      load_req = 1'b0;

      // Frame: 00 (noise), 55, N=2, 0x0007, 0xEC10
      v(8'h00,1,0, 1,0,0,16'h0000,1,0,0);
      v(8'h55,1,0, 1,0,0,16'h0000,1,0,0);
      v(8'h00,1,0, 1,0,0,16'h0000,1,0,0);
      v(8'h02,1,0, 1,0,0,16'h0000,1,0,0);
      v(8'h00,1,0, 1,0,0,16'h0000,1,0,0);
      v(8'h07,1,0, 0,1,0,16'h0007,1,0,0);
      v(8'h00,0,0, 1,0,0,16'h0007,1,0,0);
      v(8'hEC,1,0, 1,0,0,16'h0007,1,0,0);
      v(8'h10,1,0, 0,1,1,16'hEC10,1,0,0);
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      v(8'h00,0,0, 1,0,1,16'hEC10,1,0,0);
      v(8'hEC,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h17,1,0, 0,0,1,16'hEC10,0,1,0);
`else
      v(8'h00,0,0, 0,0,1,16'hEC10,0,1,0);
`endif
      v(8'h55,1,0, 0,0,1,16'hEC10,0,1,0);
      // Empty image
      v(8'h00,0,1, 1,0,1,16'hEC10,1,0,0);
      v(8'h55,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h00,1,0, 1,0,1,16'hEC10,1,0,0);
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      v(8'h00,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h00,1,0, 1,0,1,16'hEC10,1,0,0);
`endif
      v(8'h00,1,0, 0,0,1,16'hEC10,0,1,0);
      // N=32769 is too large; N=32768 is accepted
      v(8'h00,0,1, 1,0,1,16'hEC10,1,0,0);
      v(8'h55,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h80,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h01,1,0, 0,0,1,16'hEC10,1,0,1);
      v(8'h00,1,0, 0,0,1,16'hEC10,1,0,1);
      v(8'h00,0,1, 1,0,1,16'hEC10,1,0,0);
      v(8'h55,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h80,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h00,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h00,0,1, 1,0,1,16'hEC10,1,0,0);
      // Abort mid-image (byte CD arrives with load_req), then a fresh 1-word frame
      v(8'h55,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h00,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h03,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h12,1,0, 1,0,1,16'hEC10,1,0,0);
      v(8'h34,1,0, 0,1,0,16'h1234,1,0,0);
      v(8'h00,0,0, 1,0,0,16'h1234,1,0,0);
      v(8'hAB,1,0, 1,0,0,16'h1234,1,0,0);
      v(8'hCD,1,1, 1,0,0,16'h1234,1,0,0);
      v(8'h55,1,0, 1,0,0,16'h1234,1,0,0);
      v(8'h00,1,0, 1,0,0,16'h1234,1,0,0);
      v(8'h01,1,0, 1,0,0,16'h1234,1,0,0);
      v(8'h00,1,0, 1,0,0,16'h1234,1,0,0);
      v(8'h42,1,0, 0,1,0,16'h0042,1,0,0);
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      v(8'h00,0,0, 1,0,0,16'h0042,1,0,0);
      v(8'h00,1,0, 1,0,0,16'h0042,1,0,0);
      v(8'h42,1,0, 0,0,0,16'h0042,0,1,0);
`else
      v(8'h00,0,0, 0,0,0,16'h0042,0,1,0);
`endif

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", cur_out(), out_t'({1'b1, 1'b0, 15'd0, 16'h0000, 1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rx_data  = vecs[i].data;
         rx_valid = vecs[i].valid;
         load_req = vecs[i].lreq;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), cur_out(), vecs[i].exp);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      load_req = 1'b0;

      // 4-word image with rx_valid gaps
      exp_addr = '{15'd0, 15'd1, 15'd2, 15'd3};
      exp_data = '{16'h1111, 16'h2222, 16'hA5A5, 16'h0F0F};
      frame = '{8'h55, 8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22,
                8'hA5, 8'hA5, 8'h0F, 8'h0F};
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      frame.push_back(8'hE7);
      frame.push_back(8'hE7);
`endif
      pulse_load();
      send_frame(frame, 30);
      check("gap_write_count", wr_addr.size(), 4);
      for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
         check($sformatf("gap_addr%0d", i), wr_addr[i], exp_addr[i]);
         check($sformatf("gap_data%0d", i), wr_data[i], exp_data[i]);
      end
      check("gap_run", {loaded, cpu_reset, error}, 3'b100);

`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      frame = '{8'h55, 8'h00, 8'h02, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00};
      pulse_load();
      send_frame(frame, 100);
      check("csum_match_run", {loaded, cpu_reset, error}, 3'b100);
      frame = '{8'h55, 8'h00, 8'h02, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h01};
      pulse_load();
      send_frame(frame, 100);
      check("csum_mismatch_error", {loaded, cpu_reset, error, rx_ready}, 4'b0110);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rom_boot_loader
